lpc_stream_arbiter: RTL and testbench
=====================================

# lpc_stream_arbiter

Frame-level round-robin arbiter that shares one `lpc_encoder` between `NUM_CH` sample sources. It grants the encoder's 16-bit sample input to one channel for one whole frame, from first sample through `T_LAST`. It then tags the encoder's 80-bit coded output with the originating channel number, so downstream logic can demultiplex it. It sits directly in front of and behind `lpc_encoder`, and carries the encoder's valid/ready/last handshakes on both sides.

## Interface
Parameters:
- `NUM_CH`, 4, number of requesting channels (2..8).
- `CH_W`, 2, width of channel index; must equal clog2(`NUM_CH`).
- `TAG_DEPTH`, 4, depth of the channel-tag FIFO, i.e. max frames in flight inside the encoder (power of 2, ≥2).

Ports:
- `ACLK`  in  1  clock; all logic on rising edge.
- `ARESET_N`  in  1  reset, asynchronous, active-low.
- `CH_EN`  in  `NUM_CH`  per-channel grant enable.
- `S_DATA`  in  `NUM_CH`*16  channel samples; channel i at bits [16i+15:16i].
- `S_VALID`  in  `NUM_CH`  per-channel sample valid.
- `S_LAST`  in  `NUM_CH`  per-channel last sample of frame.
- `S_READY`  out  `NUM_CH`  per-channel ready.
- `ENC_SOURCE`  out  16  to encoder `IN_SOURCE`.
- `ENC_VALID`  out  1  to encoder `IN_VALID`.
- `ENC_LAST`  out  1  to encoder `T_LAST`.
- `ENC_READY`  in  1  from encoder `READY`.
- `ENC_CODED`  in  80  from encoder `OUT_CODED`.
- `ENC_OUT_VALID`  in  1  from encoder `OUT_VALID`.
- `ENC_OUT_LAST`  in  1  from encoder `OUT_LAST`.
- `ENC_T_READY`  out  1  to encoder `T_READY`.
- `M_CODED`  out  80  tagged coded word.
- `M_VALID`  out  1  coded word valid.
- `M_LAST`  out  1  last coded word of frame.
- `M_CH`  out  `CH_W`  channel that produced the current coded word.
- `M_READY`  in  1  downstream ready.
- `BUSY`  out  1  high while in STREAM.

## Operation
- A handshake is valid&ready high on the same rising edge. A frame is the samples of one channel up to and including the one with `S_LAST`.
- FSM states:
  - IDLE:
    - Eligible channel i requires `S_VALID[i] & CH_EN[i]`, and tag FIFO count < `TAG_DEPTH`.
    - If any channel is eligible, register the grant `g` and go to STREAM.
    - Search starts at `ptr` and wraps modulo `NUM_CH`; the first eligible channel wins. On grant, `ptr` ← g+1 mod `NUM_CH`.
  - STREAM: mux channel g to the encoder combinationally:
    - `ENC_SOURCE`=S_DATA[g], `ENC_VALID`=S_VALID[g], `ENC_LAST`=S_LAST[g].
    - `S_READY[g]`=`ENC_READY`; all other `S_READY` are 0.
    - On a handshake with `S_LAST[g]`=1: push g into the tag FIFO, return to IDLE.
- In IDLE, `ENC_VALID`, `ENC_LAST` and all `S_READY` are 0, and `ENC_SOURCE`=0.
- Clearing `CH_EN[g]` or `S_VALID[g]` mid-frame does not abort the frame; the grant holds until `S_LAST` is accepted.
- Output path (combinational pass-through):
  - `M_CODED`=`ENC_CODED`, `M_LAST`=`ENC_OUT_LAST`, `M_CH`=tag FIFO head.
  - `M_VALID`=`ENC_OUT_VALID` & !tag_empty.
  - `ENC_T_READY`=`M_READY` & !tag_empty.
  - A handshake with `ENC_OUT_LAST`=1 pops the tag FIFO.
- Tag FIFO:
  - Count width is clog2(`TAG_DEPTH`)+1.
  - Read/write pointers wrap modulo `TAG_DEPTH`.
  - Push and pop on the same cycle leave the count unchanged.
  - Push is never blocked: the grant requires free space, and at most one frame is open.
- Tag empty while the encoder asserts `ENC_OUT_VALID` is a protocol violation. The required response is a stall (`ENC_T_READY`=0, `M_VALID`=0); no output is generated.

## Timing
- Reset values:
  - `S_READY`=0, `ENC_SOURCE`=0, `ENC_VALID`=0, `ENC_LAST`=0, `ENC_T_READY`=0.
  - `M_VALID`=0, `M_LAST`=0, `M_CH`=0, `M_CODED`=`ENC_CODED` (pass-through), `BUSY`=0.
  - FSM=IDLE, `ptr`=0, tag FIFO empty.
- Reset asserted mid-frame: return to the reset state immediately (asynchronous). The partial frame is dropped, and no tag is pushed for it.
- Grant latency: one cycle from an eligible `S_VALID` in IDLE to the first possible sample handshake. There is exactly one idle bubble between back-to-back frames.
- Sample path and coded path add zero cycles of latency (combinational muxing).
- `ENC_READY` low stalls the granted channel with no duplicated or lost samples.

## Test plan
- Single channel, frame: ch1 sends 100,200,300,400 with `S_LAST` on 400.
  - Encoder sees 100,200,300,400 and `ENC_LAST` with 400; the first handshake occurs 1 cycle after `S_VALID[1]` rises.
  - The returned coded word has `M_CH`=1 and `M_LAST`=1.
- All 4 channels valid continuously, `CH_EN`=4'b1111: frame grants in order 0,1,2,3,0, and `M_CH` follows the same order. With `CH_EN`=4'b1010, the grant order is 1,3,1.
- Backpressure: `ENC_READY` low for 3 cycles after sample 2 of a ch2 frame.
  - `S_READY[2]` is low for those 3 cycles.
  - Encoder receives each sample exactly once; the frame completes in 4 handshakes.
- Tag full: `TAG_DEPTH`=2, `M_READY`=0, two frames accepted.
  - A third requester gets no grant and `BUSY` stays 0.
  - After one coded word with `ENC_OUT_LAST` is accepted (`M_READY`=1), the third frame is granted 1 cycle later.
- Orphan output: `ENC_OUT_VALID`=1 with the tag FIFO empty gives `M_VALID`=0 and `ENC_T_READY`=0 for as long as the condition lasts.
- Reset mid-frame: `ARESET_N` low during sample 3 of a ch3 frame.
  - All outputs hold reset values while reset is low.
  - After release with channels 0 and 3 both valid, channel 0 is granted first, and no tag for ch3's partial frame appears.

Source files
------------

// File: rtl/lpc_stream_arbiter.sv
// rtl/lpc_stream_arbiter.sv - frame-level round-robin arbiter in front of lpc_encoder
// Grants the encoder to one channel per frame and tags coded output with its channel.
module lpc_stream_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET_N,
  input  logic [NUM_CH-1:0]    CH_EN,
  input  logic [NUM_CH*16-1:0] S_DATA,
  input  logic [NUM_CH-1:0]    S_VALID,
  input  logic [NUM_CH-1:0]    S_LAST,
  output logic [NUM_CH-1:0]    S_READY,
  output logic [15:0]          ENC_SOURCE,
  output logic                 ENC_VALID,
  output logic                 ENC_LAST,
  input  logic                 ENC_READY,
  input  logic [79:0]          ENC_CODED,
  input  logic                 ENC_OUT_VALID,
  input  logic                 ENC_OUT_LAST,
  output logic                 ENC_T_READY,
  output logic [79:0]          M_CODED,
  output logic                 M_VALID,
  output logic                 M_LAST,
  output logic [CH_W-1:0]      M_CH,
  input  logic                 M_READY,
  output logic                 BUSY
);

  localparam int TP_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W = TP_W + 1;

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t           state_q, state_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;

  logic [CH_W-1:0]  tag_mem_q [TAG_DEPTH];
  logic [TP_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [15:0]      s_data_arr [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic             tag_empty, tag_has_space, push, pop, any_elig;
  logic [CH_W-1:0]  pick, cand;

  function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int unsigned off);
    return CH_W'((32'(base) + off) % 32'(NUM_CH));
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign s_data_arr[i] = S_DATA[16*i +: 16];
  end

  assign tag_empty     = (count_q == '0);
  assign tag_has_space = (count_q < CNT_W'(TAG_DEPTH));
  assign elig          = S_VALID & CH_EN & {NUM_CH{tag_has_space}};

  // The tag is pushed on the very edge the last sample is accepted, so the
  // tag is always ahead of the coded word the encoder produces for it.
  assign push = (state_q == ST_STREAM) & S_VALID[grant_q] & ENC_READY & S_LAST[grant_q];
  assign pop  = ENC_OUT_VALID & ENC_T_READY & ENC_OUT_LAST;

  // Scan downward so the lowest offset from ptr_q overrides and wins.
  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ch_add(ptr_q, 32'(k));
      if (elig[cand]) begin
        any_elig = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          state_d = ST_STREAM;
          grant_d = pick;
          ptr_d   = ch_add(pick, 32'd1);
        end
      end
      ST_STREAM: begin
        if (push) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    S_READY    = '0;
    ENC_SOURCE = '0;
    ENC_VALID  = 1'b0;
    ENC_LAST   = 1'b0;
    BUSY       = 1'b0;
    if (state_q == ST_STREAM) begin
      ENC_SOURCE       = s_data_arr[grant_q];
      ENC_VALID        = S_VALID[grant_q];
      ENC_LAST         = S_LAST[grant_q];
      S_READY[grant_q] = ENC_READY;
      BUSY             = 1'b1;
    end
  end

  // An empty tag FIFO with coded data pending is a protocol violation: stall it.
  assign M_CODED     = ENC_CODED;
  assign M_LAST      = ENC_OUT_LAST;
  assign M_VALID     = ENC_OUT_VALID & ~tag_empty;
  assign ENC_T_READY = M_READY & ~tag_empty;
  assign M_CH        = tag_empty ? '0 : tag_mem_q[rd_ptr_q];

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      if (push) begin
        tag_mem_q[wr_ptr_q] <= grant_q;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_stream_arbiter.sv
// tb/tb_lpc_stream_arbiter.sv - self-checking bench for lpc_stream_arbiter
// The bench plays both the sample sources and the encoder; frame order comes from a frame-level round-robin model.
module tb_lpc_stream_arbiter;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int TD  = 2;

  logic             ACLK = 1'b0;
  logic             ARESET_N;
  logic [NCH-1:0]   CH_EN;
  logic [NCH*16-1:0] S_DATA;
  logic [NCH-1:0]   S_VALID, S_LAST, S_READY;
  logic [15:0]      ENC_SOURCE;
  logic             ENC_VALID, ENC_LAST, ENC_READY;
  logic [79:0]      ENC_CODED;
  logic             ENC_OUT_VALID, ENC_OUT_LAST, ENC_T_READY;
  logic [79:0]      M_CODED;
  logic             M_VALID, M_LAST;
  logic [CHW-1:0]   M_CH;
  logic             M_READY, BUSY;

  lpc_stream_arbiter #(.NUM_CH(NCH), .CH_W(CHW), .TAG_DEPTH(TD)) dut (
    .ACLK(ACLK), .ARESET_N(ARESET_N), .CH_EN(CH_EN), .S_DATA(S_DATA),
    .S_VALID(S_VALID), .S_LAST(S_LAST), .S_READY(S_READY),
    .ENC_SOURCE(ENC_SOURCE), .ENC_VALID(ENC_VALID), .ENC_LAST(ENC_LAST),
    .ENC_READY(ENC_READY), .ENC_CODED(ENC_CODED), .ENC_OUT_VALID(ENC_OUT_VALID),
    .ENC_OUT_LAST(ENC_OUT_LAST), .ENC_T_READY(ENC_T_READY), .M_CODED(M_CODED),
    .M_VALID(M_VALID), .M_LAST(M_LAST), .M_CH(M_CH), .M_READY(M_READY), .BUSY(BUSY)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] src_q [NCH][$];
  logic [16:0] exp_enc [$];
  int          exp_ch [$];
  logic [79:0] coded_q [$];
  int          m_ptr = 0;
  int          n_enc_hs = 0;
  int          stall_cnt = 0;
  bit          rnd_mode = 0, m_rnd = 0, m_force = 1, orphan = 0, coded_pop = 0;
  logic [NCH-1:0] ch_en = '1;
  logic [NCH-1:0] pop_mask = '0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [79:0] rand80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  task automatic drive();
    logic [16:0] h;
    for (int c = 0; c < NCH; c++) begin
      if (src_q[c].size() > 0) begin
        h = src_q[c][0];
        S_VALID[c] = 1'b1;
        S_DATA[c*16 +: 16] = h[15:0];
        S_LAST[c] = h[16];
      end else begin
        S_VALID[c] = 1'b0;
        S_DATA[c*16 +: 16] = 16'h0;
        S_LAST[c] = 1'b0;
      end
    end
    CH_EN = ch_en;
    if (stall_cnt > 0) begin
      ENC_READY = 1'b0;
      stall_cnt--;
    end else begin
      ENC_READY = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    M_READY       = m_rnd ? 1'($urandom_range(0, 1)) : m_force;
    ENC_OUT_VALID = orphan || (coded_q.size() > 0);
    ENC_OUT_LAST  = (coded_q.size() > 0);
    ENC_CODED     = (coded_q.size() > 0) ? coded_q[0] : rand80();
  endtask

  // Observe at the falling edge: handshakes seen here complete on the next rising edge.
  task automatic sample();
    logic [16:0] e;
    @(negedge ACLK);
    pop_mask  = '0;
    coded_pop = 0;
    for (int c = 0; c < NCH; c++)
      if (S_VALID[c] && S_READY[c]) pop_mask[c] = 1'b1;
    if (ENC_VALID && ENC_READY) begin
      n_enc_hs++;
      if (exp_enc.size() == 0) begin
        check("enc_unexpected_valid", 80'(ENC_VALID), 80'(0));
      end else begin
        e = exp_enc.pop_front();
        check("enc_data", 80'(ENC_SOURCE), 80'(e[15:0]));
        check("enc_last", 80'(ENC_LAST), 80'(e[16]));
        if (ENC_LAST) coded_q.push_back(rand80());
      end
    end
    if (ENC_OUT_VALID && ENC_T_READY) begin
      if (exp_ch.size() == 0 || coded_q.size() == 0) begin
        check("out_unexpected_tready", 80'(ENC_T_READY), 80'(0));
      end else begin
        check("m_valid", 80'(M_VALID), 80'(1));
        check("m_ch", 80'(M_CH), 80'(exp_ch.pop_front()));
        check("m_coded", M_CODED, coded_q[0]);
        check("m_last", 80'(M_LAST), 80'(1));
        coded_pop = 1;
      end
    end
  endtask

  task automatic advance();
    @(posedge ACLK);
    #1;
    for (int c = 0; c < NCH; c++)
      if (pop_mask[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    if (coded_pop) void'(coded_q.pop_front());
    pop_mask  = '0;
    coded_pop = 0;
    drive();
  endtask

  task automatic load_frame(input int ch, input int len);
    for (int i = 0; i < len; i++) src_q[ch].push_back({(i == len - 1), 16'($urandom)});
  endtask

  // Frame-level model: every enabled channel with queued frames is always requesting,
  // so grants simply rotate from the pointer over channels that still have frames.
  task automatic plan();
    int cur [NCH];
    bit found;
    logic [16:0] w;
    for (int c = 0; c < NCH; c++) cur[c] = 0;
    do begin
      found = 0;
      for (int k = 0; k < NCH && !found; k++) begin
        int cc;
        cc = (m_ptr + k) % NCH;
        if (ch_en[cc] && cur[cc] < src_q[cc].size()) begin
          found = 1;
          do begin
            w = src_q[cc][cur[cc]];
            cur[cc]++;
            exp_enc.push_back(w);
          end while (!w[16]);
          exp_ch.push_back(cc);
          m_ptr = (cc + 1) % NCH;
        end
      end
    end while (found);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_enc.size() + exp_ch.size() + coded_q.size()) != 0 && n < budget) begin
      sample();
      advance();
      n++;
    end
    check(tag, 80'(exp_enc.size() + exp_ch.size() + coded_q.size()), 80'(0));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_s_ready"}, 80'(S_READY), 80'(0));
    check({tag, "_enc_source"}, 80'(ENC_SOURCE), 80'(0));
    check({tag, "_enc_valid"}, 80'(ENC_VALID), 80'(0));
    check({tag, "_enc_last"}, 80'(ENC_LAST), 80'(0));
    check({tag, "_enc_t_ready"}, 80'(ENC_T_READY), 80'(0));
    check({tag, "_m_valid"}, 80'(M_VALID), 80'(0));
    check({tag, "_m_last"}, 80'(M_LAST), 80'(0));
    check({tag, "_m_ch"}, 80'(M_CH), 80'(0));
    check({tag, "_m_coded"}, M_CODED, ENC_CODED);
    check({tag, "_busy"}, 80'(BUSY), 80'(0));
  endtask

  initial begin
    int h0;
    S_DATA = '0; S_VALID = '0; S_LAST = '0;

    // Reset state, with sources requesting and an orphan coded word present.
    ARESET_N = 1'b0;
    orphan   = 1;
    for (int c = 0; c < NCH; c++) load_frame(c, 2);
    drive();
    sample();
    reset_checks("rst");
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    orphan = 0;
    advance();
    ARESET_N = 1'b1;
    advance();

    // Single ch1 frame 100,200,300,400; first handshake one cycle after S_VALID rises.
    src_q[1].push_back({1'b0, 16'd100});
    src_q[1].push_back({1'b0, 16'd200});
    src_q[1].push_back({1'b0, 16'd300});
    src_q[1].push_back({1'b1, 16'd400});
    plan();
    advance();
    sample();
    check("t1_busy_idle", 80'(BUSY), 80'(0));
    check("t1_s_ready_idle", 80'(S_READY), 80'(0));
    advance();
    sample();
    check("t1_s_ready_grant", 80'(S_READY), 80'(4'b0010));
    check("t1_first_sample", 80'(ENC_SOURCE), 80'(100));
    check("t1_busy", 80'(BUSY), 80'(1));
    advance();
    run_until_idle("t1_drain", 60);

    // Fresh pointer, all enabled: grants 0,1,2,3,0.
    ARESET_N = 1'b0;
    m_ptr    = 0;
    advance();
    ARESET_N = 1'b1;
    load_frame(0, 3); load_frame(0, 2);
    load_frame(1, 1); load_frame(2, 4); load_frame(3, 2);
    plan();
    advance();
    run_until_idle("rr_all_drain", 200);

    // Only ch1 and ch3 enabled: grants 1,3,1; ch0/ch2 never serviced.
    ch_en = 4'b1010;
    load_frame(0, 2); load_frame(2, 2);
    load_frame(1, 2); load_frame(1, 3); load_frame(3, 1);
    plan();
    advance();
    run_until_idle("rr_mask_drain", 200);
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    ch_en = '1;
    advance();

    // Backpressure: ENC_READY low for 3 cycles after sample 2 of a ch2 frame.
    load_frame(2, 4);
    plan();
    advance();
    h0 = n_enc_hs;
    for (int i = 0; i < 20 && (n_enc_hs - h0) < 2; i++) begin
      sample();
      advance();
    end
    check("bp_two_hs", 80'(n_enc_hs - h0), 80'(2));
    ENC_READY = 1'b0;
    stall_cnt = 2;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("bp_s_ready_low", 80'(S_READY[2]), 80'(0));
      advance();
    end
    run_until_idle("bp_drain", 60);
    check("bp_four_hs", 80'(n_enc_hs - h0), 80'(4));

    // Tag FIFO full: third requester waits until a coded word drains.
    m_force = 0;
    load_frame(0, 1); load_frame(1, 1); load_frame(2, 1);
    plan();
    advance();
    for (int i = 0; i < 12; i++) begin
      sample();
      advance();
    end
    sample();
    check("full_busy", 80'(BUSY), 80'(0));
    check("full_s_ready", 80'(S_READY), 80'(0));
    check("full_pending", 80'(exp_enc.size()), 80'(1));
    m_force = 1;
    advance();
    sample();
    check("full_t_ready", 80'(ENC_T_READY), 80'(1));
    advance();
    sample();
    advance();
    sample();
    check("full_grant_after_pop", 80'(BUSY), 80'(1));
    advance();
    run_until_idle("full_drain", 60);

    // Orphan coded output: stalled while tags are empty.
    orphan = 1;
    advance();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("orphan_m_valid", 80'(M_VALID), 80'(0));
      check("orphan_t_ready", 80'(ENC_T_READY), 80'(0));
      advance();
    end
    orphan = 0;
    advance();

    // Randomized rounds with random masks, frame lengths and both-side backpressure.
    rnd_mode = 1;
    m_rnd    = 1;
    for (int r = 0; r < 6; r++) begin
      ch_en = 4'($urandom_range(1, 15));
      for (int c = 0; c < NCH; c++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) load_frame(c, $urandom_range(1, 5));
      end
      plan();
      advance();
      run_until_idle("rand_drain", 800);
      for (int c = 0; c < NCH; c++) src_q[c].delete();
      ch_en = '1;
      advance();
    end
    rnd_mode = 0;
    m_rnd    = 0;
    m_force  = 1;
    advance();

    // Reset during sample 3 of a ch3 frame; partial frame dropped, ch0 then wins.
    load_frame(3, 5);
    plan();
    advance();
    h0 = n_enc_hs;
    for (int i = 0; i < 20 && (n_enc_hs - h0) < 2; i++) begin
      sample();
      advance();
    end
    check("rst_mid_two_hs", 80'(n_enc_hs - h0), 80'(2));
    ARESET_N = 1'b0;
    src_q[3].delete();
    exp_enc.delete();
    exp_ch.delete();
    coded_q.delete();
    m_ptr = 0;
    drive();
    sample();
    reset_checks("rst_mid");
    load_frame(0, 2);
    load_frame(3, 3);
    plan();
    advance();
    sample();
    reset_checks("rst_hold");
    advance();
    ARESET_N = 1'b1;
    run_until_idle("rst_after_drain", 80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
